pdp_cal2d_pad_line_unpack: RTL and testbench

//  Consumer of the d3 pad-line word (fp16_mul_pad_line_in_*_d3) in the PDP cal2d fp16 path.

---
 rtl/pdp_cal2d_pkg.sv | 23 ++
 rtl/pdp_cal2d_lane_sel.sv | 18 +
 rtl/pdp_cal2d_pad_line_unpack.sv | 93 +++++++++
 tb/tb_pdp_cal2d_pad_line_unpack.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp_cal2d_pkg.sv
// Shared sizes, field offsets and FSM state encoding for the PDP cal2d fp16 pad-line unpacker.
package pdp_cal2d_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 7;
  localparam int CNT_W     = 3;
  localparam int LANES_W   = NUM_LANES * LANE_W;
  localparam int PD_W      = LANES_W + CNT_W;
  localparam int CNT_LSB   = LANES_W;

  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(NUM_LANES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A count field of 3'b111 would mean 8 lanes, which the word cannot carry.
  function automatic logic [CNT_W-1:0] clamp_lim(input logic [CNT_W-1:0] cnt);
    return (cnt > MAX_IDX) ? MAX_IDX : cnt;
  endfunction

endpackage

// File: rtl/pdp_cal2d_lane_sel.sv
// Combinational lane mux: picks one fp16 lane out of the held word by index.
// Zero latency, no flow control.
module pdp_cal2d_lane_sel
  import pdp_cal2d_pkg::*;
(
  input  logic [LANES_W-1:0] hold_pd_i,
  input  logic [CNT_W-1:0]   idx_i,
  output logic [LANE_W-1:0]  lane_o
);

  always_comb begin
    lane_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx_i == CNT_W'(i)) lane_o = hold_pd_i[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/pdp_cal2d_pad_line_unpack.sv
// Serialises one 7-lane fp16 pad-line word into 16-bit beats; lane 0 one cycle after accept, next word loads
// on the last-lane take (no bubble); output holds under rdy low. Optional PDP_PAD_LINE_STALL_CNT_EN stall counter.
module pdp_cal2d_pad_line_unpack
  import pdp_cal2d_pkg::*;
(
  input  logic              nvdla_op_gated_clk_fp16,
  input  logic              nvdla_core_rstn,
  input  logic [PD_W-1:0]   fp16_mul_pad_line_in_pd_d3,
  input  logic              fp16_mul_pad_line_in_vld_d3,
  output logic              fp16_mul_pad_line_in_rdy_d3,
  output logic [LANE_W-1:0] pad_line_lane_pd_d4,
  output logic [CNT_W-1:0]  pad_line_lane_idx_d4,
  output logic              pad_line_lane_last_d4,
  output logic              pad_line_lane_vld_d4,
  input  logic              pad_line_lane_rdy_d4,
  output logic [31:0]       pad_line_stall_cnt
);

  state_e               state_q;
  logic [LANES_W-1:0]   hold_pd_q;
  logic [CNT_W-1:0]     idx_q;
  logic [CNT_W-1:0]     idx_d;
  logic [CNT_W-1:0]     lim_q;
  logic [CNT_W-1:0]     lim_d;
  logic                 vld_q;
  logic                 last_q;
  logic                 take;
  logic                 accept;

  assign take   = vld_q & pad_line_lane_rdy_d4;
  // Ready never looks at the input valid, so an X valid mid-word cannot leak into state.
  assign fp16_mul_pad_line_in_rdy_d3 = (state_q == IDLE) | (take & last_q);
  assign accept = fp16_mul_pad_line_in_vld_d3 & fp16_mul_pad_line_in_rdy_d3;
  assign lim_d  = clamp_lim(fp16_mul_pad_line_in_pd_d3[CNT_LSB +: CNT_W]);
  assign idx_d  = idx_q + CNT_W'(1);

  always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      lim_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      state_q <= SHIFT;
      vld_q   <= 1'b1;
      idx_q   <= '0;
      lim_q   <= lim_d;
      last_q  <= (lim_d == '0);
    end else if (state_q == SHIFT && take) begin
      if (last_q) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        idx_q   <= idx_d;
        last_q  <= (idx_d == lim_q);
      end
    end
  end

  // Payload register carries no reset; it is only observed while vld_q is high.
  always_ff @(posedge nvdla_op_gated_clk_fp16) begin
    if (accept) hold_pd_q <= fp16_mul_pad_line_in_pd_d3[LANES_W-1:0];
  end

  pdp_cal2d_lane_sel u_lane_sel (
    .hold_pd_i (hold_pd_q),
    .idx_i     (idx_q),
    .lane_o    (pad_line_lane_pd_d4)
  );

  assign pad_line_lane_idx_d4  = idx_q;
  assign pad_line_lane_last_d4 = last_q;
  assign pad_line_lane_vld_d4  = vld_q;

`ifdef PDP_PAD_LINE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge nvdla_op_gated_clk_fp16 or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_cnt_q <= '0;
    end else if (vld_q && !pad_line_lane_rdy_d4 && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign pad_line_stall_cnt = stall_cnt_q;
`else
  assign pad_line_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pdp_cal2d_pad_line_unpack.sv
// Directed and random checks of the pad-line unpacker; inputs driven on negedge, outputs sampled 1ns later.
module tb_pdp_cal2d_pad_line_unpack;

  logic         clk;
  logic         rstn;
  logic [114:0] pd_d3;
  logic         vld_d3;
  logic         rdy_d3;
  logic [15:0]  lane_pd;
  logic [2:0]   lane_idx;
  logic         lane_last;
  logic         lane_vld;
  logic         lane_rdy;
  logic [31:0]  stall_cnt;

  int n_checks;
  int n_fail;

  pdp_cal2d_pad_line_unpack dut (
    .nvdla_op_gated_clk_fp16     (clk),
    .nvdla_core_rstn             (rstn),
    .fp16_mul_pad_line_in_pd_d3  (pd_d3),
    .fp16_mul_pad_line_in_vld_d3 (vld_d3),
    .fp16_mul_pad_line_in_rdy_d3 (rdy_d3),
    .pad_line_lane_pd_d4         (lane_pd),
    .pad_line_lane_idx_d4        (lane_idx),
    .pad_line_lane_last_d4       (lane_last),
    .pad_line_lane_vld_d4        (lane_vld),
    .pad_line_lane_rdy_d4        (lane_rdy),
    .pad_line_stall_cnt          (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [114:0] mkword(input logic [15:0] base, input logic [2:0] cnt);
    logic [114:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) w[i*16 +: 16] = base + 16'(i);
    w[114:112] = cnt;
    return w;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; vld_d3 = 1'b0; lane_rdy = 1'b1; pd_d3 = '0;
    #1;
    n_checks++;
    if (lane_vld !== 1'b0 || lane_idx !== 3'd0 || lane_last !== 1'b0 || rdy_d3 !== 1'b1 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: vld=%b idx=%0d last=%b rdy_d3=%b stall=%0d, want 0 0 0 1 0",
               lane_vld, lane_idx, lane_last, rdy_d3, stall_cnt);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_word();
    @(negedge clk);
    pd_d3 = mkword(16'h1000, 3'd6); vld_d3 = 1'b1; lane_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vld_d3 = 1'b0; pd_d3 = {115{1'b1}};
      #1;
      n_checks++;
      if (i < 7) begin
        if (lane_vld !== 1'b1 || lane_idx !== 3'(i) || lane_pd !== 16'h1000 + 16'(i) || lane_last !== (i == 6)) begin
          n_fail++;
          $display("FAIL single_beat%0d: vld=%b idx=%0d pd=%h last=%b, want 1 %0d %h %b",
                   i, lane_vld, lane_idx, lane_pd, lane_last, i, 16'h1000 + 16'(i), (i == 6));
        end
      end else if (lane_vld !== 1'b0 || rdy_d3 !== 1'b1) begin
        n_fail++;
        $display("FAIL single_idle: vld=%b rdy_d3=%b, want 0 1", lane_vld, rdy_d3);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pd_d3 = mkword(16'hA000, 3'd1); vld_d3 = 1'b1; lane_rdy = 1'b1;
    @(negedge clk);
    pd_d3 = mkword(16'hB000, 3'd0);
    #1;
    n_checks++;
    if (lane_vld !== 1'b1 || lane_pd !== 16'hA000 || lane_idx !== 3'd0 || lane_last !== 1'b0 || rdy_d3 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_A0: vld=%b pd=%h idx=%0d last=%b rdy_d3=%b, want 1 a000 0 0 0",
               lane_vld, lane_pd, lane_idx, lane_last, rdy_d3);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (lane_vld !== 1'b1 || lane_pd !== 16'hA001 || lane_idx !== 3'd1 || lane_last !== 1'b1 || rdy_d3 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_A1: vld=%b pd=%h idx=%0d last=%b rdy_d3=%b, want 1 a001 1 1 1",
               lane_vld, lane_pd, lane_idx, lane_last, rdy_d3);
    end
    @(negedge clk);
    vld_d3 = 1'b0;
    #1;
    n_checks++;
    if (lane_vld !== 1'b1 || lane_pd !== 16'hB000 || lane_idx !== 3'd0 || lane_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_B0: vld=%b pd=%h idx=%0d last=%b, want 1 b000 0 1",
               lane_vld, lane_pd, lane_idx, lane_last);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (lane_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: vld=%b, want 0", lane_vld);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_stall;
`ifdef PDP_PAD_LINE_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    @(negedge clk);
    pd_d3 = mkword(16'h2000, 3'd6); vld_d3 = 1'b1; lane_rdy = 1'b1;
    repeat (3) @(negedge clk);
    vld_d3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      lane_rdy = (c == 5);
      #1;
      n_checks++;
      if (lane_vld !== 1'b1 || lane_idx !== 3'd2 || lane_pd !== 16'h2002 || lane_last !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: vld=%b idx=%0d pd=%h last=%b, want 1 2 2002 0",
                 c, lane_vld, lane_idx, lane_pd, lane_last);
      end
      if (c < 5) @(negedge clk);
    end
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d, want %0d", stall_cnt, exp_stall);
    end
    for (int i = 3; i < 7; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (lane_vld !== 1'b1 || lane_idx !== 3'(i) || lane_pd !== 16'h2000 + 16'(i) || lane_last !== (i == 6)) begin
        n_fail++;
        $display("FAIL stall_drain%0d: vld=%b idx=%0d pd=%h last=%b", i, lane_vld, lane_idx, lane_pd, lane_last);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_clamp();
    @(negedge clk);
    pd_d3 = mkword(16'h3000, 3'b111); vld_d3 = 1'b1; lane_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vld_d3 = 1'b0;
      #1;
      n_checks++;
      if (i < 7) begin
        if (lane_vld !== 1'b1 || lane_idx !== 3'(i) || lane_pd !== 16'h3000 + 16'(i) || lane_last !== (i == 6)) begin
          n_fail++;
          $display("FAIL clamp_beat%0d: vld=%b idx=%0d pd=%h last=%b", i, lane_vld, lane_idx, lane_pd, lane_last);
        end
      end else if (lane_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL clamp_extra: vld=%b idx=%0d, want vld 0", lane_vld, lane_idx);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    pd_d3 = mkword(16'h4000, 3'd6); vld_d3 = 1'b1; lane_rdy = 1'b1;
    @(negedge clk);
    vld_d3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (lane_vld !== 1'b1 || lane_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_pre: vld=%b idx=%0d, want 1 3", lane_vld, lane_idx);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (lane_vld !== 1'b0 || lane_idx !== 3'd0 || lane_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: vld=%b idx=%0d last=%b, want 0 0 0", lane_vld, lane_idx, lane_last);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_checks++;
    if (rdy_d3 !== 1'b1 || lane_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: rdy_d3=%b vld=%b, want 1 0", rdy_d3, lane_vld);
    end
    @(negedge clk);
    pd_d3 = mkword(16'h5000, 3'd2); vld_d3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld_d3 = 1'b0;
      #1;
      n_checks++;
      if (lane_vld !== 1'b1 || lane_idx !== 3'(i) || lane_pd !== 16'h5000 + 16'(i) || lane_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL rst_next%0d: vld=%b idx=%0d pd=%h last=%b", i, lane_vld, lane_idx, lane_pd, lane_last);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [19:0]  q[$];
    logic [19:0]  ent;
    logic [114:0] cur;
    logic [2:0]   lim;
    for (int i = 0; i < 7; i++) cur[i*16 +: 16] = 16'($urandom);
    cur[114:112] = 3'($urandom_range(0, 7));
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge clk);
      if (cyc < 10000) begin
        vld_d3   = ($urandom_range(0, 3) != 0);
        lane_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        vld_d3   = 1'b0;
        lane_rdy = 1'b1;
      end
      pd_d3 = vld_d3 ? cur : {4'h0, 111'($urandom)};
      #1;
      if (lane_vld && lane_rdy) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: beat pd=%h idx=%0d with empty scoreboard", lane_pd, lane_idx);
        end else begin
          ent = q.pop_front();
          if ({lane_last, lane_idx, lane_pd} !== ent) begin
            n_fail++;
            if (n_fail < 20)
              $display("FAIL rand_beat cyc%0d: last=%b idx=%0d pd=%h, want last=%b idx=%0d pd=%h",
                       cyc, lane_last, lane_idx, lane_pd, ent[19], ent[18:16], ent[15:0]);
          end
        end
      end
      if (vld_d3 && rdy_d3) begin
        lim = (cur[114:112] == 3'd7) ? 3'd6 : cur[114:112];
        for (int i = 0; i <= int'(lim); i++) q.push_back({(i == int'(lim)), 3'(i), cur[i*16 +: 16]});
        for (int i = 0; i < 7; i++) cur[i*16 +: 16] = 16'($urandom);
        cur[114:112] = 3'($urandom_range(0, 7));
      end
    end
    n_checks++;
    if (q.size() != 0 || lane_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d beats never emitted, vld=%b", q.size(), lane_vld);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_clamp();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
